// File: rtl/vga_line_fetch_scheduler.sv
// Shares the single-port frame-buffer SRAM between display line prefetch and
// the edge-detection writer, filling a ping-pong line buffer one line ahead.
module vga_line_fetch_scheduler #(
    parameter int HACTIVE        = 640,
    parameter int VACTIVE        = 480,
    parameter int VTOTAL         = 525,
    parameter int PIX_PER_WORD   = 4,
    parameter int WORDS_PER_LINE = HACTIVE / PIX_PER_WORD,
    parameter int ADDR_W         = 17,
    parameter int DATA_W         = 32,
    parameter int LB_AW          = 8
) (
    input  logic              vgaClk,
    input  logic              nrst,
    input  logic [9:0]        hCount,
    input  logic [9:0]        vCount,
    input  logic              wrReq,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [DATA_W-1:0] wrData,
    output logic              wrGnt,
    output logic [ADDR_W-1:0] memAddr,
    output logic              memWe,
    output logic [DATA_W-1:0] memWdata,
    input  logic [DATA_W-1:0] memRdata,
    output logic              lbWe,
    output logic              lbBank,
    output logic [LB_AW-1:0]  lbAddr,
    output logic [DATA_W-1:0] lbData,
    output logic              busy,
    output logic              underrun
);

    localparam logic [9:0]       V_LAST   = 10'(VTOTAL - 1);
    localparam logic [9:0]       V_ACT_M1 = 10'(VACTIVE - 1);
    localparam logic [LB_AW-1:0] K_LAST   = LB_AW'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  base_q, base_d;
    logic               bank_q, bank_d;
    logic [LB_AW-1:0]   k_q, k_d;
    logic               toggle_q, toggle_d;
    logic               underrun_q, underrun_d;
    logic               rdValid_q, rdValid_d;
    logic [LB_AW-1:0]   rdIdx_q, rdIdx_d;
    logic               rdBank_q, rdBank_d;

    logic               targetValid;
    logic [9:0]         targetLine;
    logic [ADDR_W-1:0]  targetBase;
    logic               trigger;
    logic               inFetch;
    logic               dispRead;

    // The last blanking line prefetches line 0 of the next frame.
    always_comb begin
        targetValid = 1'b0;
        targetLine  = '0;
        if (vCount == V_LAST) begin
            targetValid = 1'b1;
            targetLine  = '0;
        end else if (vCount < V_ACT_M1) begin
            targetValid = 1'b1;
            targetLine  = vCount + 10'd1;
        end
    end

    assign targetBase = ADDR_W'(32'(targetLine) * WORDS_PER_LINE);
    assign trigger    = (hCount == 10'd0) && targetValid;

    // toggle_q low means display owns the next contended slot.
    assign inFetch  = (state_q == FETCH);
    assign dispRead = inFetch && (!wrReq || !toggle_q);
    assign wrGnt    = nrst && wrReq && !dispRead;

    always_comb begin
        memAddr  = '0;
        memWe    = 1'b0;
        memWdata = '0;
        if (wrGnt) begin
            memAddr  = wrAddr;
            memWe    = 1'b1;
            memWdata = wrData;
        end else if (dispRead) begin
            memAddr  = base_q + ADDR_W'(k_q);
        end
    end

    // A new trigger always restarts the fetch, even over one in progress.
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        bank_d     = bank_q;
        k_d        = k_q;
        toggle_d   = toggle_q;
        underrun_d = underrun_q;

        if (inFetch && wrReq) begin
            toggle_d = ~toggle_q;
        end

        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            FETCH: begin
                if (dispRead) begin
                    k_d = k_q + LB_AW'(1);
                    if (k_q == K_LAST) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (trigger) begin
            state_d  = FETCH;
            base_d   = targetBase;
            bank_d   = targetLine[0];
            k_d      = '0;
            toggle_d = 1'b0;
            if (state_q != IDLE) begin
                underrun_d = 1'b1;
            end
        end
    end

    // Read return tracking keeps the bank/index of the read that was issued,
    // so an abandoned fetch still lands its final word correctly.
    always_comb begin
        rdValid_d = dispRead;
        rdIdx_d   = rdIdx_q;
        rdBank_d  = rdBank_q;
        if (dispRead) begin
            rdIdx_d  = k_q;
            rdBank_d = bank_q;
        end
    end

    always_ff @(posedge vgaClk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= IDLE;
            base_q     <= '0;
            bank_q     <= 1'b0;
            k_q        <= '0;
            toggle_q   <= 1'b0;
            underrun_q <= 1'b0;
            rdValid_q  <= 1'b0;
            rdIdx_q    <= '0;
            rdBank_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            bank_q     <= bank_d;
            k_q        <= k_d;
            toggle_q   <= toggle_d;
            underrun_q <= underrun_d;
            rdValid_q  <= rdValid_d;
            rdIdx_q    <= rdIdx_d;
            rdBank_q   <= rdBank_d;
        end
    end

    assign lbWe     = rdValid_q;
    assign lbAddr   = rdIdx_q;
    assign lbBank   = rdBank_q;
    assign lbData   = memRdata;
    assign busy     = (state_q != IDLE);
    assign underrun = underrun_q;

endmodule

// File: doc/vga_line_fetch_scheduler.md
# vga_line_fetch_scheduler

Arbitrates the single-port frame-buffer SRAM between two requesters: display line prefetch and the edge-detection pipeline writer. It watches the VGA timing counters. During each scan line it fetches the next visible line into a ping-pong line buffer that the pixel output stage reads. The edge-detection result writer gets all remaining SRAM slots, with a guaranteed share while a fetch is in progress.

## Interface
Parameters:
- HACTIVE, 640, visible pixels per line
- VACTIVE, 480, visible lines per frame
- VTOTAL, 525, total lines per frame; vCount runs 0..VTOTAL-1
- PIX_PER_WORD, 4, pixels per SRAM word
- WORDS_PER_LINE, HACTIVE/PIX_PER_WORD (160), SRAM words per line
- ADDR_W, 17, SRAM word address width
- DATA_W, 32, SRAM word width
- LB_AW, 8, line-buffer word index width

Ports:
- vgaClk  in  1  pixel clock; all logic on the rising edge
- nrst  in  1  reset, asynchronous, active-low
- hCount  in  10  horizontal counter from the VGA timing generator
- vCount  in  10  vertical counter from the VGA timing generator
- wrReq  in  1  writer request; held with wrAddr/wrData until granted
- wrAddr  in  ADDR_W  writer word address
- wrData  in  DATA_W  writer data
- wrGnt  out  1  combinational grant; the write occurs on this cycle's edge
- memAddr  out  ADDR_W  SRAM address (combinational)
- memWe  out  1  SRAM write enable
- memWdata  out  DATA_W  SRAM write data
- memRdata  in  DATA_W  SRAM read data; valid one cycle after the read is issued
- lbWe  out  1  line-buffer write enable (registered)
- lbBank  out  1  line-buffer bank; equals target line[0]
- lbAddr  out  LB_AW  line-buffer word index
- lbData  out  DATA_W  line-buffer data; equals memRdata
- busy  out  1  high in FETCH or DRAIN
- underrun  out  1  sticky; cleared only by reset

## Operation
- Fetch trigger: a cycle with hCount==0.
  - vCount==VTOTAL-1: target line 0.
  - vCount<VACTIVE-1: target line vCount+1.
  - Any other vCount: no fetch.
- Base address: target*WORDS_PER_LINE, truncated to ADDR_W.
- State machine:
  - IDLE: on a trigger with a valid target, go to FETCH. Latch the base address and bank. Clear the word counter k.
  - FETCH: each cycle that display owns the slot, issue read base+k (memWe=0) and increment k. After issuing word WORDS_PER_LINE-1, go to DRAIN.
  - DRAIN: one cycle for the last read's data return, then go to IDLE.
- Arbitration, per cycle:
  - Not in FETCH: the writer always wins when wrReq=1.
  - In FETCH with wrReq=0: display wins.
  - In FETCH with wrReq=1: the winner alternates, starting with display on the first FETCH cycle. The toggle advances only on contended cycles.
- Writer grant: wrGnt=1 drives memAddr=wrAddr, memWe=1, memWdata=wrData.
- Idle slot: neither requester owns the slot → memAddr=0, memWe=0.
- Read return: a read of word k issued in cycle N gives lbWe=1, lbAddr=k, lbBank=latched bank, lbData=memRdata in cycle N+1.
- Trigger while busy: a valid trigger in FETCH or DRAIN sets underrun. The current fetch is abandoned; no further reads are issued for it. A new FETCH starts for the new target. Any in-flight read return still completes with its old bank and index.
- Reset: returns to IDLE. The next fetch starts only at the next valid trigger.

## Timing
- Reset values: wrGnt=0, memWe=0, memAddr=0, memWdata=0, lbWe=0, lbBank=0, lbAddr=0, busy=0, underrun=0. The toggle resets to favour display.
- Trigger at cycle T: busy rises at T+1 and the first read is issued at T+1.
- Uncontended fetch:
  - Reads are issued at T+1..T+160.
  - lbWe pulses at T+2..T+161.
  - busy falls after T+161, i.e. low at T+162.
- Fully contended fetch: reads are issued on alternate cycles. The last read is issued at T+319 and busy is low at T+321. This fits within the 800-cycle line period.
- wrGnt has zero latency from wrReq. A held request is granted within 2 cycles, even during a fetch.

## Test plan
- Reset: hold nrst low with wrReq=1 → all outputs at their reset values. Release with hCount≠0 → wrGnt=1 immediately, busy=0.
- Fetch, no writer: hCount=0, vCount=4 → memAddr steps 800..959 over 160 consecutive cycles with memWe=0. lbWe pulses with lbAddr 0..159 and lbBank=1. busy is high for 161 cycles.
- Contention: wrReq held high through a trigger at vCount=10 → grants alternate display/writer. 160 reads go to addresses 1760..1919 and 159 writes occur before the last read. busy is low 321 cycles after the trigger.
- Frame wrap and blanking:
  - vCount=524, hCount=0 → reads of addresses 0..159 into bank 0.
  - vCount=479 or 500, hCount=0 → busy stays 0.
- Underrun: bench jumps hCount to 0 at vCount=20 while fetching line 6 → underrun=1 and stays set. A new fetch of addresses 3360.. starts into bank 1.
- Reset mid-fetch: nrst low at word 50 → outputs reset asynchronously. After release there are no reads until the next hCount==0.
